banco_registros_param: RTL and testbench
========================================

BANCO_REGISTROS_PARAM -- requirements
Module: banco_registros_param

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; number of registers NREG = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 readReg1, readReg2  input  ADDR_W  read port addresses.
REQ-007 readData1, readData2  output  DATA_W  read port data.
REQ-008 writeReg  input  ADDR_W  write address.
REQ-009 writeData  input  DATA_W  write data.
REQ-010 RegWrite  input  1  write enable.
REQ-011 setBusy  input  1  mark register busySel as pending (long-latency producer issued).
REQ-012 busySel  input  ADDR_W  register to mark busy.
REQ-013 busy1, busy2  output  1  pending flag of readReg1 / readReg2.
REQ-014 nWrites  output  16  saturating count of committed writes since reset.

Function
REQ-015 Write: on rising CLK with RegWrite=1, reg[writeReg] <= writeData; one-cycle latency.
REQ-016 Read: readDataN combinational from reg[readRegN], no clock latency.
REQ-017 ZERO_REG=1: writes to address 0 are discarded, readDataN=0 for address 0, busy never set for address 0, and such writes do not increment nWrites.
REQ-018 Busy scoreboard: per-register bit; setBusy=1 sets bit[busySel] at rising CLK.
REQ-019 A committed write to register r clears bit[r] at the same rising CLK.
REQ-020 setBusy and write to the same register in the same cycle: busy bit ends set (new producer wins).
REQ-021 busyN = bit[readRegN] combinational, subject to REQ-025 when bypass is compiled in.
REQ-022 nWrites increments by 1 per committed write; saturates at 16'hFFFF, no wrap.
REQ-023 Writes to any address other than 0 (or all addresses if ZERO_REG=0) behave identically; address NREG-1 is fully usable.

Reset
REQ-024 RESET=1 asynchronously clears all registers to 0, all busy bits to 0, and nWrites to 0; all outputs read 0 while RESET is asserted; writes and setBusy are ignored during reset, and a write in flight when RESET asserts is lost.

Configuration
REQ-025 Macro BANCO_BYPASS_EN defined: write-to-read forwarding is compiled in, so when RegWrite=1 and writeReg==readRegN (non-zero address if ZERO_REG=1), readDataN=writeData and busyN=0 in the same cycle.
REQ-026 BANCO_BYPASS_EN undefined: no forwarding, so readDataN shows the old value until the cycle after the write edge, and busyN reflects stored bits only.

Verification
REQ-027 Reset: write 32'h1234 to reg 7, assert RESET mid-cycle -> readData1 for reg 7 = 0 immediately, nWrites=0, busy1=0.
REQ-028 Register zero: write 32'h00A1 to reg 0, then read reg 0 -> readData1=0 and nWrites unchanged.
REQ-029 Write/read: write 32'hA234 to reg 13, read it on both ports next cycle -> readData1=readData2=32'hA234, nWrites=1.
REQ-030 Simultaneous write and read of reg 5, old value 32'h1, new value 32'hBEEF -> readData1=32'hBEEF in the same cycle with BANCO_BYPASS_EN, and 32'h1 until the next edge without it.
REQ-031 Scoreboard: setBusy on reg 9 -> busy1=1 for readReg1=9; a later write to reg 9 -> busy1=0 after the edge; setBusy plus write to reg 9 in the same cycle -> busy1=1.
REQ-032 Saturation: 65536 writes to reg 3 -> nWrites=16'hFFFF, with no wrap to 0.

Source files
------------

// File: rtl/banco_registros_param.sv
// Parameterised register file with two combinational read ports, one write port,
// a per-register busy scoreboard and a saturating count of committed writes.
// Optional feature: define BANCO_BYPASS_EN to forward the write port onto the
// read ports in the same cycle (data and busy flag).
module banco_registros_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              RegWrite,
    input  logic              setBusy,
    input  logic [ADDR_W-1:0] busySel,
    output logic              busy1,
    output logic              busy2,
    output logic [15:0]       nWrites
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [15:0]       n_writes_q;

    logic wr_commit;
    logic busy_commit;
    logic [DATA_W-1:0] raw_data1;
    logic [DATA_W-1:0] raw_data2;

    // Writes/marks to the hardwired zero register are dropped; nothing commits in reset.
    assign wr_commit   = RegWrite && !RESET && !(ZERO_REG && (writeReg == '0));
    assign busy_commit = setBusy && !RESET && !(ZERO_REG && (busySel == '0));

    // Scoreboard next state: a write clears its bit, a new producer sets it (set wins).
    always_comb begin
        busy_d = busy_q;
        if (wr_commit) begin
            busy_d[writeReg] = 1'b0;
        end
        if (busy_commit) begin
            busy_d[busySel] = 1'b1;
        end
    end

    // Register storage.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[writeReg] <= writeData;
        end
    end

    // Busy scoreboard state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Committed-write counter, sticks at all ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            n_writes_q <= '0;
        end else if (wr_commit && (n_writes_q != 16'hFFFF)) begin
            n_writes_q <= n_writes_q + 16'd1;
        end
    end

    // Stored read data, forcing zero for the hardwired register.
    always_comb begin
        raw_data1 = (ZERO_REG && (readReg1 == '0)) ? '0 : regs_q[readReg1];
        raw_data2 = (ZERO_REG && (readReg2 == '0)) ? '0 : regs_q[readReg2];
    end

`ifdef BANCO_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forward the in-flight write; a forwarded value is never pending.
    always_comb begin
        fwd1      = wr_commit && (writeReg == readReg1);
        fwd2      = wr_commit && (writeReg == readReg2);
        readData1 = fwd1 ? writeData : raw_data1;
        readData2 = fwd2 ? writeData : raw_data2;
        busy1     = busy_q[readReg1] && !fwd1;
        busy2     = busy_q[readReg2] && !fwd2;
    end
`else
    // Stored values and stored busy bits only.
    always_comb begin
        readData1 = raw_data1;
        readData2 = raw_data2;
        busy1     = busy_q[readReg1];
        busy2     = busy_q[readReg2];
    end
`endif

    assign nWrites = n_writes_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed, table-driven bench for banco_registros_param (default parameters).
module tb_banco_registros_param;

`ifdef BANCO_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  readReg1, readReg2, writeReg, busySel;
    logic [31:0] readData1, readData2, writeData;
    logic        RegWrite, setBusy, busy1, busy2;
    logic [15:0] nWrites;

    int passed = 0;
    int total  = 0;

    banco_registros_param dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .RegWrite  (RegWrite),
        .setBusy   (setBusy),
        .busySel   (busySel),
        .busy1     (busy1),
        .busy2     (busy2),
        .nWrites   (nWrites)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        sb;
        logic [4:0]  bsel;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [15:0] e_nw;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        // Expected values are the pre-edge outputs; the row's write lands at the next edge.
        //            wr    wreg   wdata          sb    bsel   r1     r2     rd1            rd2            b1    b2    nw
        vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd31, 32'h0,         32'h0,         1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 5'd13, 32'hA234,      1'b0, 5'd0,  5'd1,  5'd2,  32'h0,         32'h0,         1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd13, 5'd13, 32'hA234,      32'hA234,      1'b0, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 5'd0,  32'h00A1,      1'b0, 5'd0,  5'd13, 5'd1,  32'hA234,      32'h0,         1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd13, 32'h0,         32'hA234,      1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 5'd31, 32'hDEADBEEF,  1'b0, 5'd0,  5'd13, 5'd0,  32'hA234,      32'h0,         1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd31, 5'd13, 32'hDEADBEEF,  32'hA234,      1'b0, 1'b0, 16'd2};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd9,  5'd31, 32'h0,         32'hDEADBEEF,  1'b0, 1'b0, 16'd2};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd9,  32'h0,         32'h0,         1'b1, 1'b1, 16'd2};
        vecs[9]  = '{1'b1, 5'd9,  32'h99,        1'b0, 5'd0,  5'd13, 5'd31, 32'hA234,      32'hDEADBEEF,  1'b0, 1'b0, 16'd2};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd13, 32'h99,        32'hA234,      1'b0, 1'b0, 16'd3};
        vecs[11] = '{1'b1, 5'd9,  32'h55,        1'b1, 5'd9,  5'd31, 5'd13, 32'hDEADBEEF,  32'hA234,      1'b0, 1'b0, 16'd3};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd0,  32'h55,        32'h0,         1'b1, 1'b0, 16'd4};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd9,  32'h0,         32'h55,        1'b0, 1'b1, 16'd4};
        vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd9,  32'h0,         32'h55,        1'b0, 1'b1, 16'd4};
        vecs[15] = '{1'b1, 5'd5,  32'h1,         1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 16'd4};

        RESET = 1'b1; RegWrite = 1'b0; setBusy = 1'b0;
        writeReg = '0; writeData = '0; busySel = '0; readReg1 = 5'd7; readReg2 = 5'd31;
        #3;
        check("rst_rd1", readData1, 32'h0);
        check("rst_rd2", readData2, 32'h0);
        check("rst_nw", {16'h0, nWrites}, 32'h0);
        check("rst_busy", {30'h0, busy1, busy2}, 32'h0);
        #9 RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 16; i++) begin
            RegWrite = vecs[i].wr; writeReg = vecs[i].wreg; writeData = vecs[i].wdata;
            setBusy = vecs[i].sb; busySel = vecs[i].bsel;
            readReg1 = vecs[i].r1; readReg2 = vecs[i].r2;
            #3;
            check($sformatf("v%0d_rd1", i), readData1, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), readData2, vecs[i].e_rd2);
            check($sformatf("v%0d_busy", i), {30'h0, busy1, busy2},
                  {30'h0, vecs[i].e_b1, vecs[i].e_b2});
            check($sformatf("v%0d_nw", i), {16'h0, nWrites}, {16'h0, vecs[i].e_nw});
            @(posedge CLK); #1;
        end

        // Same-cycle write/read of reg 5 (old 1, new BEEF).
        setBusy = 1'b0;
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'hBEEF; readReg1 = 5'd5; readReg2 = 5'd5;
        #3;
        check("fwd_rd1_same", readData1, Byp ? 32'hBEEF : 32'h1);
        check("fwd_rd2_same", readData2, Byp ? 32'hBEEF : 32'h1);
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        #3;
        check("fwd_rd1_next", readData1, 32'hBEEF);
        check("fwd_nw", {16'h0, nWrites}, 32'd6);

        // Reg 9 is still pending from the set+write row; write it again.
        RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h77; readReg1 = 5'd9;
        #3;
        check("sb_busy_same", {31'h0, busy1}, Byp ? 32'h0 : 32'h1);
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        #3;
        check("sb_busy_after", {31'h0, busy1}, 32'h0);
        check("sb_rd1_after", readData1, 32'h77);
        check("sb_nw", {16'h0, nWrites}, 32'd7);

        // Reset mid-cycle with a write and a busy mark in flight.
        RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h1234; readReg1 = 5'd7;
        @(posedge CLK); #1;
        RegWrite = 1'b0; setBusy = 1'b1; busySel = 5'd7;
        #3;
        check("r7_written", readData1, 32'h1234);
        check("r7_nw", {16'h0, nWrites}, 32'd8);
        @(posedge CLK); #1;
        setBusy = 1'b0;
        #1;
        check("r7_busy", {31'h0, busy1}, 32'h1);
        RegWrite = 1'b1; writeData = 32'h5555; setBusy = 1'b1; busySel = 5'd7;
        readReg2 = 5'd5;
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_rd1", readData1, 32'h0);
        check("mid_rst_rd2", readData2, 32'h0);
        check("mid_rst_nw", {16'h0, nWrites}, 32'h0);
        check("mid_rst_busy", {31'h0, busy1}, 32'h0);
        @(posedge CLK); #1;
        check("held_rst_rd1", readData1, 32'h0);
        check("held_rst_busy", {31'h0, busy1}, 32'h0);
        check("held_rst_nw", {16'h0, nWrites}, 32'h0);
        #3;
        RESET = 1'b0; RegWrite = 1'b0; setBusy = 1'b0;
        #1;
        check("post_rst_rd1", readData1, 32'h0);
        check("post_rst_nw", {16'h0, nWrites}, 32'h0);

        // Saturation: 65536 writes to reg 3.
        @(posedge CLK); #1;
        RegWrite = 1'b1; writeReg = 5'd3; readReg1 = 5'd3;
        for (int i = 0; i < 65535; i++) begin
            writeData = i;
            @(posedge CLK); #1;
        end
        #2;
        check("sat_nw_ffff", {16'h0, nWrites}, 32'hFFFF);
        writeData = 32'hCAFE;
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        #2;
        check("sat_nw_nowrap", {16'h0, nWrites}, 32'hFFFF);
        check("sat_rd1", readData1, 32'hCAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
